ysyx_23060124_issue_ctrl: RTL and testbench
===========================================

# ysyx_23060124_issue_ctrl

Issue controller for the IDU→EXU pipeline register. It holds a per-register scoreboard of in-flight writes and gates issue on read-after-write hazards. It serializes fence.i/ecall/mret/ebreak until the back end is empty and sequences a one-cycle flush on EXU redirect. Its `o_rf_valid` drives the IDU/EXU register's `i_rf_valid` gate, and its `o_flush` drives that register's flush.

## Interface
- No parameters. Scoreboard depth is fixed at 32 registers with 2-bit counters.
- `clock` in 1: sole clock.
- `reset` in 1: asynchronous, active-low.
- `i_id_valid` in 1: IDU holds a decoded instruction.
- `i_rs1`, `i_rs2` in 5 each: source register indices.
- `i_rs1_used`, `i_rs2_used` in 1 each: the source is actually read.
- `i_rd` in 5, `i_wen` in 1: destination register and its write enable.
- `i_serial` in 1: instruction is fence.i, ecall, mret or ebreak.
- `i_ex_ready` in 1: EXU side can accept a new register load.
- `i_ex_fire` in 1: EXU consumed the instruction held in the IDU/EXU register.
- `i_wb_valid` in 1, `i_wb_rd` in 5, `i_wb_wen` in 1: WBU commit.
- `i_lsu_idle` in 1: no outstanding bus transaction.
- `i_redirect` in 1: one-cycle taken branch, jump or trap from EXU.
- `o_rf_valid` out 1: operands are hazard-free and issue is permitted.
- `o_issue` out 1: `i_id_valid & i_ex_ready & o_rf_valid`.
- `o_flush` out 1: kill the IDU/EXU register and the IDU contents.
- `o_sb_empty` out 1: all scoreboard counters are zero.
- `o_stall_cnt` out 32, `o_drain_cnt` out 32: present only with `YSYX_23060124_ISSUE_STAT_EN`.

## Operation
- Scoreboard `cnt[1..31]`, 2 bits each. `cnt[0]` is hard-wired to 0.
- Increment `cnt[i_rd]` on `o_issue & i_wen & i_rd!=0`.
- Decrement `cnt[i_wb_rd]` on `i_wb_valid & i_wb_wen & i_wb_rd!=0`.
- When the increment and decrement target the same register in the same cycle, the counter is unchanged.
- Hazard is `(i_rs1_used & cnt[i_rs1]!=0) | (i_rs2_used & cnt[i_rs2]!=0) | (i_wen & cnt[i_rd]==3)`. The last term is a saturation stall; the counter never wraps.
- Slot tracker (`slot_v`, `slot_rd`, `slot_wen`) mirrors the IDU/EXU register contents:
  - set on `o_issue`;
  - cleared on `i_ex_fire` without `o_issue`;
  - replaced when `o_issue` and `i_ex_fire` occur in the same cycle.
- FSM states and transitions:
  - RUN: `o_rf_valid = ~hazard & ~i_serial`.
    - `i_id_valid & i_serial` → DRAIN.
    - `i_redirect` → FLUSH (priority over all other transitions).
  - DRAIN: `o_rf_valid = o_sb_empty & i_lsu_idle & ~slot_v`.
    - `o_issue` → RUN.
    - `i_redirect` → FLUSH.
  - FLUSH: `o_rf_valid = 0`, `o_flush = 1`.
    - If `slot_v & slot_wen & slot_rd!=0`, decrement `cnt[slot_rd]` (combined with a same-cycle WB decrement, saturating at 0).
    - Clear `slot_v`. Next state RUN.
- `i_redirect` in FLUSH is ignored. A redirect arriving in the same cycle as `o_issue` still flushes, and the just-issued slot is the one undone.
- Underflow is not allowed: a decrement of a zero counter leaves it at 0 and fires a simulation assertion.

## Timing
- `o_rf_valid`, `o_issue` and `o_sb_empty` are combinational from registered state and the current inputs; issue has zero-cycle latency.
- Scoreboard updates are visible the cycle after the edge.
- There is no WB→issue bypass: a consumer issues in cycle T+1 after a commit in cycle T, when the register file already holds the value.
- Redirect in cycle T: FLUSH during T+1, RUN at T+2. `o_flush` is high only in T+1.
- Reset (asserted asynchronously, mid-operation included) forces:
  - state RUN, all `cnt` and `slot_v` to 0;
  - `o_flush=0`, `o_sb_empty=1`;
  - stat counters to 0.
- While reset is asserted, `o_rf_valid` and `o_issue` follow their combinational equations (`o_issue = i_id_valid & i_ex_ready` for non-serial, hazard-free input).

## Configuration
- `YSYX_23060124_ISSUE_STAT_EN` defined:
  - `o_stall_cnt` increments each cycle with `i_id_valid & ~o_rf_valid` in RUN;
  - `o_drain_cnt` increments each cycle spent in DRAIN;
  - both are 32-bit free-running and wrap at 2^32.
- Undefined: both ports are absent and no counter logic is built.

## Structure
- Shared package `ysyx_23060124_pkg` holds:
  - FSM state encoding `ISSUE_RUN=2'd0`, `ISSUE_DRAIN=2'd1`, `ISSUE_FLUSH=2'd2`;
  - `SB_MAX=2'd3`.
- One sub-module, `ysyx_23060124_scoreboard`, holds the 31×2-bit counters with one increment port, two decrement ports (WB, flush), read ports `rs1`/`rs2`/`rd`, and an `empty` flag. The FSM and slot tracker stay in the top module.

## Test plan
- Issue `addi x5` (wen) → `cnt[5]=1`. Next cycle `add x6,x5,x1` → `o_rf_valid=0` until WB commits x5; `o_issue` is asserted the cycle after the commit.
- Three back-to-back writes to x7 with no WB → `cnt[7]=3`, and a fourth writer to x7 stalls. One WB of x7 → the fourth issues the next cycle.
- Issue of x9 and WB of x9 in the same cycle → `cnt[9]` is unchanged; an x0 destination never stalls a reader of x0.
- fence.i with `cnt[3]=1` → state DRAIN, `o_rf_valid=0`. After WB x3 and `i_lsu_idle=1` → fence.i issues and the FSM returns to RUN; with the macro defined, `o_drain_cnt` equals the DRAIN cycle count.
- Slot holds `lw x8`, `i_redirect` pulse → `o_flush=1` for exactly one cycle, `cnt[8]` back to 0, `slot_v=0`, RUN on the following cycle.
- Drive reset low mid-DRAIN with nonzero counters → immediately RUN, `o_sb_empty=1`, `o_flush=0`.

Source files
------------

// File: rtl/ysyx_23060124_issue_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_pkg
// Shared definitions for the IDU->EXU issue controller: FSM state encoding,
// scoreboard counter limit and register-file geometry.
// ---------------------------------------------------------------------------
package ysyx_23060124_pkg;

  typedef enum logic [1:0] {
    ISSUE_RUN   = 2'd0,
    ISSUE_DRAIN = 2'd1,
    ISSUE_FLUSH = 2'd2
  } issue_state_e;

  // Largest number of in-flight writes tracked per register.
  localparam logic [1:0] SB_MAX = 2'd3;

  localparam int SB_REGS = 32;

endpackage

// File: rtl/ysyx_23060124_issue_ctrl_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_issue_ctrl_if
// Bundles the decode, EXU, WBU and LSU status signals seen by the issue
// controller, plus its issue/flush outputs.
//   master : pipeline side (drives i_*, observes o_*)
//   slave  : issue controller (observes i_*, drives o_*)
// Optional statistics outputs o_stall_cnt / o_drain_cnt exist only when
// YSYX_23060124_ISSUE_STAT_EN is defined.
// ---------------------------------------------------------------------------
interface ysyx_23060124_issue_ctrl_if;
  import ysyx_23060124_pkg::*;

  logic       i_id_valid;
  logic [4:0] i_rs1;
  logic [4:0] i_rs2;
  logic       i_rs1_used;
  logic       i_rs2_used;
  logic [4:0] i_rd;
  logic       i_wen;
  logic       i_serial;
  logic       i_ex_ready;
  logic       i_ex_fire;
  logic       i_wb_valid;
  logic [4:0] i_wb_rd;
  logic       i_wb_wen;
  logic       i_lsu_idle;
  logic       i_redirect;
  logic       o_rf_valid;
  logic       o_issue;
  logic       o_flush;
  logic       o_sb_empty;
`ifdef YSYX_23060124_ISSUE_STAT_EN
  logic [31:0] o_stall_cnt;
  logic [31:0] o_drain_cnt;

  modport master (
    output i_id_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd, i_wen,
           i_serial, i_ex_ready, i_ex_fire, i_wb_valid, i_wb_rd, i_wb_wen,
           i_lsu_idle, i_redirect,
    input  o_rf_valid, o_issue, o_flush, o_sb_empty, o_stall_cnt, o_drain_cnt
  );

  modport slave (
    input  i_id_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd, i_wen,
           i_serial, i_ex_ready, i_ex_fire, i_wb_valid, i_wb_rd, i_wb_wen,
           i_lsu_idle, i_redirect,
    output o_rf_valid, o_issue, o_flush, o_sb_empty, o_stall_cnt, o_drain_cnt
  );
`else
  modport master (
    output i_id_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd, i_wen,
           i_serial, i_ex_ready, i_ex_fire, i_wb_valid, i_wb_rd, i_wb_wen,
           i_lsu_idle, i_redirect,
    input  o_rf_valid, o_issue, o_flush, o_sb_empty
  );

  modport slave (
    input  i_id_valid, i_rs1, i_rs2, i_rs1_used, i_rs2_used, i_rd, i_wen,
           i_serial, i_ex_ready, i_ex_fire, i_wb_valid, i_wb_rd, i_wb_wen,
           i_lsu_idle, i_redirect,
    output o_rf_valid, o_issue, o_flush, o_sb_empty
  );
`endif

endinterface

// File: rtl/ysyx_23060124_scoreboard.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_scoreboard
// Per-register count of in-flight writes (x1..x31, 2 bits each; x0 is
// always zero).
//   clock, reset          : clock, asynchronous active-low reset
//   inc_en / inc_rd       : one more write in flight to inc_rd
//   wb_dec_en / wb_dec_rd : WBU committed a write to wb_dec_rd
//   fl_dec_en / fl_dec_rd : flushed instruction's write is cancelled
//   rs1, rs2, rd          : read-port indices
//   rs1_cnt .. rd_cnt     : counts for the read ports
//   empty                 : every counter is zero
// ---------------------------------------------------------------------------
module ysyx_23060124_scoreboard
  import ysyx_23060124_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       inc_en,
  input  logic [4:0] inc_rd,
  input  logic       wb_dec_en,
  input  logic [4:0] wb_dec_rd,
  input  logic       fl_dec_en,
  input  logic [4:0] fl_dec_rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic [4:0] rd,
  output logic [1:0] rs1_cnt,
  output logic [1:0] rs2_cnt,
  output logic [1:0] rd_cnt,
  output logic       empty
);

  logic [1:0]         cnt_q [SB_REGS];
  logic [1:0]         cnt_d [SB_REGS];
  logic [SB_REGS-1:0] underflow;
  logic [2:0]         up;
  logic [2:0]         down;

  // Net change is inc - (wb + flush); a simultaneous inc and dec on the same
  // register cancels. A result below zero is clamped and flagged.
  always_comb begin
    underflow = '0;
    up        = '0;
    down      = '0;
    for (int i = 0; i < SB_REGS; i++) begin
      up   = {2'b00, inc_en && (inc_rd == 5'(i))};
      down = {2'b00, wb_dec_en && (wb_dec_rd == 5'(i))}
           + {2'b00, fl_dec_en && (fl_dec_rd == 5'(i))};
      if (i == 0) begin
        cnt_d[i] = 2'd0;
      end else if (({1'b0, cnt_q[i]} + up) < down) begin
        cnt_d[i]     = 2'd0;
        underflow[i] = 1'b1;
      end else if (({1'b0, cnt_q[i]} + up - down) > {1'b0, SB_MAX}) begin
        cnt_d[i] = SB_MAX;
      end else begin
        cnt_d[i] = 2'({1'b0, cnt_q[i]} + up - down);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SB_REGS; i++) cnt_q[i] <= 2'd0;
    end else begin
      for (int i = 0; i < SB_REGS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) assert (underflow == '0);
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 1; i < SB_REGS; i++) begin
      if (cnt_q[i] != 2'd0) empty = 1'b0;
    end
  end

  assign rs1_cnt = cnt_q[rs1];
  assign rs2_cnt = cnt_q[rs2];
  assign rd_cnt  = cnt_q[rd];

endmodule

// File: rtl/ysyx_23060124_issue_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_23060124_issue_ctrl
// Gates issue into the IDU/EXU register on RAW and write-saturation hazards,
// serializes fence.i/ecall/mret/ebreak until the back end is empty, and
// sequences a one-cycle flush after an EXU redirect.
//   clock, reset : clock, asynchronous active-low reset
//   io (slave)   : i_* decode/EXU/WBU/LSU status in,
//                  o_rf_valid, o_issue, o_flush, o_sb_empty out,
//                  o_stall_cnt, o_drain_cnt with YSYX_23060124_ISSUE_STAT_EN
// ---------------------------------------------------------------------------
module ysyx_23060124_issue_ctrl
  import ysyx_23060124_pkg::*;
(
  input  logic                         clock,
  input  logic                         reset,
  ysyx_23060124_issue_ctrl_if.slave    io
);

  issue_state_e state_q, state_d;
  logic         slot_v_q;
  logic [4:0]   slot_rd_q;
  logic         slot_wen_q;
  logic [1:0]   rs1_cnt, rs2_cnt, rd_cnt;
  logic         sb_empty;
  logic         hazard;
  logic         rf_valid;
  logic         flush;
  logic         issue;
  logic         flush_dec;

  ysyx_23060124_scoreboard u_sb (
    .clock     (clock),
    .reset     (reset),
    .inc_en    (issue && io.i_wen && (io.i_rd != 5'd0)),
    .inc_rd    (io.i_rd),
    .wb_dec_en (io.i_wb_valid && io.i_wb_wen && (io.i_wb_rd != 5'd0)),
    .wb_dec_rd (io.i_wb_rd),
    .fl_dec_en (flush_dec),
    .fl_dec_rd (slot_rd_q),
    .rs1       (io.i_rs1),
    .rs2       (io.i_rs2),
    .rd        (io.i_rd),
    .rs1_cnt   (rs1_cnt),
    .rs2_cnt   (rs2_cnt),
    .rd_cnt    (rd_cnt),
    .empty     (sb_empty)
  );

  // Last term stalls a writer whose counter is full so it never wraps.
  assign hazard = (io.i_rs1_used && (rs1_cnt != 2'd0))
               || (io.i_rs2_used && (rs2_cnt != 2'd0))
               || (io.i_wen && (rd_cnt == SB_MAX));

  always_comb begin
    state_d  = state_q;
    rf_valid = 1'b0;
    flush    = 1'b0;
    unique case (state_q)
      ISSUE_RUN: begin
        rf_valid = ~hazard & ~io.i_serial;
        if (io.i_id_valid && io.i_serial) state_d = ISSUE_DRAIN;
      end
      ISSUE_DRAIN: begin
        rf_valid = sb_empty & io.i_lsu_idle & ~slot_v_q;
        if (io.i_id_valid && io.i_ex_ready && rf_valid) state_d = ISSUE_RUN;
      end
      ISSUE_FLUSH: begin
        flush   = 1'b1;
        state_d = ISSUE_RUN;
      end
      default: state_d = ISSUE_RUN;
    endcase
    // A redirect outranks everything, but one already being flushed is ignored.
    if (io.i_redirect && (state_q != ISSUE_FLUSH)) state_d = ISSUE_FLUSH;
  end

  assign issue = io.i_id_valid & io.i_ex_ready & rf_valid;

  // The slot content at FLUSH is the youngest issued instruction; its
  // pending write is undone.
  assign flush_dec = (state_q == ISSUE_FLUSH) && slot_v_q && slot_wen_q
                  && (slot_rd_q != 5'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ISSUE_RUN;
      slot_v_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ISSUE_FLUSH) slot_v_q <= 1'b0;
      else if (issue)             slot_v_q <= 1'b1;
      else if (io.i_ex_fire)      slot_v_q <= 1'b0;
    end
  end

  // Slot payload is qualified by slot_v_q and needs no reset.
  always_ff @(posedge clock) begin
    if ((state_q != ISSUE_FLUSH) && issue) begin
      slot_rd_q  <= io.i_rd;
      slot_wen_q <= io.i_wen;
    end
  end

  assign io.o_rf_valid = rf_valid;
  assign io.o_issue    = issue;
  assign io.o_flush    = flush;
  assign io.o_sb_empty = sb_empty;

`ifdef YSYX_23060124_ISSUE_STAT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] drain_cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      if ((state_q == ISSUE_RUN) && io.i_id_valid && !rf_valid)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (state_q == ISSUE_DRAIN)
        drain_cnt_q <= drain_cnt_q + 32'd1;
    end
  end

  assign io.o_stall_cnt = stall_cnt_q;
  assign io.o_drain_cnt = drain_cnt_q;
`endif

endmodule

// File: tb/tb_ysyx_23060124_issue_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for ysyx_23060124_issue_ctrl: directed scenarios plus a
// randomized run against a behavioural model of the scoreboard, the
// serialization/flush modes and the statistics counters.
// ---------------------------------------------------------------------------
module tb_ysyx_23060124_issue_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  ysyx_23060124_issue_ctrl_if bus ();

  ysyx_23060124_issue_ctrl dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: pending write count per register, mode flags, slot.
  int          m_cnt [32];
  bit          m_drain, m_flush;
  bit          m_slot_v, m_slot_wen;
  int          m_slot_rd;
  int unsigned m_stall, m_drains;
  bit          e_rf, e_issue, e_flush, e_empty;

  task automatic drive_idle();
    bus.i_id_valid = 0; bus.i_rs1 = 0; bus.i_rs2 = 0;
    bus.i_rs1_used = 0; bus.i_rs2_used = 0; bus.i_rd = 0; bus.i_wen = 0;
    bus.i_serial = 0; bus.i_ex_ready = 1; bus.i_ex_fire = 0;
    bus.i_wb_valid = 0; bus.i_wb_rd = 0; bus.i_wb_wen = 0;
    bus.i_lsu_idle = 1; bus.i_redirect = 0;
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_drain = 0; m_flush = 0; m_slot_v = 0; m_slot_wen = 0; m_slot_rd = 0;
    m_stall = 0; m_drains = 0;
  endfunction

  function automatic void model_comb();
    bit haz;
    e_empty = 1;
    for (int r = 0; r < 32; r++) if (m_cnt[r] != 0) e_empty = 0;
    haz = (bus.i_rs1_used && m_cnt[bus.i_rs1] != 0)
       || (bus.i_rs2_used && m_cnt[bus.i_rs2] != 0)
       || (bus.i_wen && m_cnt[bus.i_rd] == 3);
    if (m_flush)      e_rf = 0;
    else if (m_drain) e_rf = e_empty && bus.i_lsu_idle && !m_slot_v;
    else              e_rf = !haz && !bus.i_serial;
    e_issue = bus.i_id_valid && bus.i_ex_ready && e_rf;
    e_flush = m_flush;
  endfunction

  function automatic void model_update();
    if (e_issue && bus.i_wen && bus.i_rd != 0) m_cnt[bus.i_rd]++;
    if (bus.i_wb_valid && bus.i_wb_wen && bus.i_wb_rd != 0 && m_cnt[bus.i_wb_rd] > 0)
      m_cnt[bus.i_wb_rd]--;
    if (m_flush && m_slot_v && m_slot_wen && m_slot_rd != 0 && m_cnt[m_slot_rd] > 0)
      m_cnt[m_slot_rd]--;
    if (!m_drain && !m_flush && bus.i_id_valid && !e_rf) m_stall++;
    if (m_drain) m_drains++;
    if (m_flush) m_slot_v = 0;
    else if (e_issue) begin
      m_slot_v = 1; m_slot_rd = int'(bus.i_rd); m_slot_wen = bus.i_wen;
    end else if (bus.i_ex_fire) m_slot_v = 0;
    if (m_flush) begin m_flush = 0; m_drain = 0; end
    else if (bus.i_redirect) begin m_flush = 1; m_drain = 0; end
    else if (m_drain) begin if (e_issue) m_drain = 0; end
    else if (bus.i_id_valid && bus.i_serial) m_drain = 1;
  endfunction

  task automatic tick();
    model_comb();
    @(posedge clock);
    model_update();
    #1;
  endtask

  // Retire everything in flight so the next scenario starts from empty.
  task automatic settle();
    drive_idle();
    bus.i_ex_fire = m_slot_v;
    tick();
    drive_idle();
    for (int r = 1; r < 32; r++) begin
      while (m_cnt[r] > 0) begin
        bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 5'(r);
        tick();
      end
    end
    drive_idle();
  endtask

  task automatic test_reset();
    drive_idle();
    bus.i_id_valid = 1;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush: got %b want 0", bus.o_flush); end
    n_checks++; if (bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL reset_sb_empty: got %b want 1", bus.o_sb_empty); end
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL reset_issue_comb: got %b want 1", bus.o_issue); end
`ifdef YSYX_23060124_ISSUE_STAT_EN
    n_checks++; if (bus.o_stall_cnt !== 32'd0 || bus.o_drain_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_stats: got %0d/%0d want 0/0", bus.o_stall_cnt, bus.o_drain_cnt); end
`endif
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    drive_idle();
    @(posedge clock);
    #1;
  endtask

  // addi x5 then add x6,x5,x1: consumer waits until the cycle after WB x5.
  task automatic test_raw();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 5; bus.i_wen = 1;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL raw_issue_producer: got %b want 1", bus.o_issue); end
    tick();
    bus.i_rs1 = 5; bus.i_rs1_used = 1; bus.i_rs2 = 1; bus.i_rs2_used = 1;
    bus.i_rd = 6; bus.i_ex_fire = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL raw_stall_%0d: got %b want 0", k, bus.o_rf_valid); end
      tick();
      bus.i_ex_fire = 0;
    end
    bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 5;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: got %b want 0", bus.o_rf_valid); end
    tick();
    bus.i_wb_valid = 0;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL raw_issue_after_wb: got %b want 1", bus.o_issue); end
    tick();
    settle();
  endtask

  // Three writers to x7 fill the counter; the fourth waits for one WB.
  task automatic test_saturation();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 7; bus.i_wen = 1;
    for (int k = 0; k < 3; k++) begin
      bus.i_ex_fire = m_slot_v;
      @(negedge clock);
      n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL sat_issue_%0d: got %b want 1", k, bus.o_issue); end
      tick();
    end
    bus.i_ex_fire = 1;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL sat_fourth_stall: got %b want 0", bus.o_rf_valid); end
    tick();
    bus.i_ex_fire = 0;
    bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 7;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL sat_stall_during_wb: got %b want 0", bus.o_rf_valid); end
    tick();
    bus.i_wb_valid = 0;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL sat_fourth_issue: got %b want 1", bus.o_issue); end
    tick();
    settle();
  endtask

  // Same-cycle issue and WB of x9 leave the count unchanged; x0 never stalls.
  task automatic test_same_cycle();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 9; bus.i_wen = 1;
    tick();
    drive_idle();
    bus.i_ex_fire = 1;
    tick();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 9; bus.i_wen = 1;
    bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 9;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL same_issue_x9: got %b want 1", bus.o_issue); end
    tick();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rs1 = 9; bus.i_rs1_used = 1; bus.i_ex_fire = 1;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL same_reader_stall: got %b want 0", bus.o_rf_valid); end
    n_checks++; if (bus.o_sb_empty !== 1'b0) begin n_fail++; $display("FAIL same_not_empty: got %b want 0", bus.o_sb_empty); end
    tick();
    bus.i_ex_fire = 0;
    bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 9;
    tick();
    bus.i_wb_valid = 0;
    @(negedge clock);
    n_checks++; if (bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL same_count_one: sb_empty got %b want 1", bus.o_sb_empty); end
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL same_reader_issue: got %b want 1", bus.o_issue); end
    tick();
    settle();
    bus.i_id_valid = 1; bus.i_rd = 0; bus.i_wen = 1;
    bus.i_rs1 = 0; bus.i_rs1_used = 1; bus.i_rs2 = 0; bus.i_rs2_used = 1;
    for (int k = 0; k < 4; k++) begin
      bus.i_ex_fire = m_slot_v;
      @(negedge clock);
      n_checks++; if (bus.o_issue !== 1'b1 || bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL x0_no_stall_%0d: issue/empty got %b/%b want 1/1", k, bus.o_issue, bus.o_sb_empty); end
      tick();
    end
    settle();
  endtask

  // fence.i behind a pending x3 write drains, then issues and returns to RUN.
  task automatic test_serial();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 3; bus.i_wen = 1;
    tick();
    drive_idle();
    bus.i_id_valid = 1; bus.i_serial = 1; bus.i_ex_fire = 1; bus.i_lsu_idle = 0;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL serial_run_block: got %b want 0", bus.o_rf_valid); end
    tick();
    bus.i_ex_fire = 0;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL serial_drain_pending: got %b want 0", bus.o_rf_valid); end
    tick();
    bus.i_wb_valid = 1; bus.i_wb_wen = 1; bus.i_wb_rd = 3;
    tick();
    bus.i_wb_valid = 0;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0 || bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL serial_lsu_busy: rf/empty got %b/%b want 0/1", bus.o_rf_valid, bus.o_sb_empty); end
    tick();
    bus.i_lsu_idle = 1;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL serial_issue: got %b want 1", bus.o_issue); end
    tick();
    bus.i_serial = 0; bus.i_ex_fire = 1;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL serial_back_to_run: got %b want 1", bus.o_issue); end
`ifdef YSYX_23060124_ISSUE_STAT_EN
    n_checks++; if (bus.o_drain_cnt !== 32'd4) begin n_fail++; $display("FAIL serial_drain_cnt: got %0d want 4", bus.o_drain_cnt); end
`endif
    tick();
    settle();
  endtask

  // Redirect with lw x8 in the slot, then redirect together with an issue.
  task automatic test_flush();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 8; bus.i_wen = 1;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL flush_issue_lw: got %b want 1", bus.o_issue); end
    tick();
    drive_idle();
    bus.i_redirect = 1;
    @(negedge clock);
    n_checks++; if (bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL flush_early: got %b want 0", bus.o_flush); end
    tick();
    bus.i_id_valid = 1;
    @(negedge clock);
    n_checks++; if (bus.o_flush !== 1'b1 || bus.o_rf_valid !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: flush/rf got %b/%b want 1/0", bus.o_flush, bus.o_rf_valid); end
    n_checks++; if (bus.o_sb_empty !== 1'b0) begin n_fail++; $display("FAIL flush_cnt_before: empty got %b want 0", bus.o_sb_empty); end
    tick();
    bus.i_redirect = 0; bus.i_serial = 1;
    @(negedge clock);
    n_checks++; if (bus.o_flush !== 1'b0 || bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL flush_single_cycle: flush/empty got %b/%b want 0/1", bus.o_flush, bus.o_sb_empty); end
    tick();
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL flush_slot_cleared: got %b want 1", bus.o_issue); end
    tick();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 10; bus.i_wen = 1; bus.i_redirect = 1; bus.i_ex_fire = 1;
    @(negedge clock);
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL flush_issue_with_redirect: got %b want 1", bus.o_issue); end
    tick();
    drive_idle();
    @(negedge clock);
    n_checks++; if (bus.o_flush !== 1'b1 || bus.o_sb_empty !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle: flush/empty got %b/%b want 1/0", bus.o_flush, bus.o_sb_empty); end
    tick();
    @(negedge clock);
    n_checks++; if (bus.o_sb_empty !== 1'b1) begin n_fail++; $display("FAIL flush_undo_issued: empty got %b want 1", bus.o_sb_empty); end
    tick();
    settle();
  endtask

  // Asynchronous reset in the middle of DRAIN with x4 and x11 in flight.
  task automatic test_reset_mid_drain();
    drive_idle();
    bus.i_id_valid = 1; bus.i_rd = 4; bus.i_wen = 1;
    tick();
    bus.i_rd = 11; bus.i_ex_fire = 1;
    tick();
    drive_idle();
    bus.i_id_valid = 1; bus.i_serial = 1; bus.i_ex_fire = 1;
    tick();
    bus.i_ex_fire = 0;
    @(negedge clock);
    n_checks++; if (bus.o_rf_valid !== 1'b0 || bus.o_sb_empty !== 1'b0) begin n_fail++; $display("FAIL rst_drain_setup: rf/empty got %b/%b want 0/0", bus.o_rf_valid, bus.o_sb_empty); end
    #1 reset = 1'b0;
    #1;
    n_checks++; if (bus.o_sb_empty !== 1'b1 || bus.o_flush !== 1'b0) begin n_fail++; $display("FAIL rst_async: empty/flush got %b/%b want 1/0", bus.o_sb_empty, bus.o_flush); end
`ifdef YSYX_23060124_ISSUE_STAT_EN
    n_checks++; if (bus.o_drain_cnt !== 32'd0 || bus.o_stall_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_stats: got %0d/%0d want 0/0", bus.o_drain_cnt, bus.o_stall_cnt); end
`endif
    bus.i_serial = 0; bus.i_rs1 = 4; bus.i_rs1_used = 1; bus.i_lsu_idle = 0;
    #1;
    n_checks++; if (bus.o_issue !== 1'b1) begin n_fail++; $display("FAIL rst_run_state: issue got %b want 1", bus.o_issue); end
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    drive_idle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_random();
    int cand[$];
    int c;
    for (int cyc = 0; cyc < 800; cyc++) begin
      drive_idle();
      bus.i_id_valid = ($urandom_range(0, 9) < 7);
      bus.i_rs1 = 5'($urandom_range(0, 7)); bus.i_rs1_used = $urandom_range(0, 1) == 1;
      bus.i_rs2 = 5'($urandom_range(0, 7)); bus.i_rs2_used = $urandom_range(0, 1) == 1;
      bus.i_serial = ($urandom_range(0, 19) == 0);
      bus.i_rd  = 5'($urandom_range(0, 7));
      bus.i_wen = !bus.i_serial && ($urandom_range(0, 3) != 0);
      bus.i_ex_ready = ($urandom_range(0, 4) != 0);
      bus.i_ex_fire  = m_slot_v && ($urandom_range(0, 1) == 1);
      bus.i_lsu_idle = ($urandom_range(0, 4) != 0);
      bus.i_redirect = ($urandom_range(0, 24) == 0);
      cand.delete();
      for (int r = 1; r < 32; r++) begin
        c = m_cnt[r] - ((m_slot_v && m_slot_wen && m_slot_rd == r) ? 1 : 0);
        if (c > 0) cand.push_back(r);
      end
      if (cand.size() > 0 && $urandom_range(0, 9) < 5) begin
        bus.i_wb_valid = 1; bus.i_wb_wen = 1;
        bus.i_wb_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
      end else if ($urandom_range(0, 9) == 0) begin
        bus.i_wb_valid = 1; bus.i_wb_wen = 0; bus.i_wb_rd = 5'($urandom_range(0, 31));
      end
      @(negedge clock);
      model_comb();
      n_checks++; if (bus.o_rf_valid !== e_rf) begin n_fail++; $display("FAIL rnd_rf_valid cyc %0d: got %b want %b", cyc, bus.o_rf_valid, e_rf); end
      n_checks++; if (bus.o_issue !== e_issue) begin n_fail++; $display("FAIL rnd_issue cyc %0d: got %b want %b", cyc, bus.o_issue, e_issue); end
      n_checks++; if (bus.o_flush !== e_flush) begin n_fail++; $display("FAIL rnd_flush cyc %0d: got %b want %b", cyc, bus.o_flush, e_flush); end
      n_checks++; if (bus.o_sb_empty !== e_empty) begin n_fail++; $display("FAIL rnd_sb_empty cyc %0d: got %b want %b", cyc, bus.o_sb_empty, e_empty); end
`ifdef YSYX_23060124_ISSUE_STAT_EN
      n_checks++; if (bus.o_stall_cnt !== m_stall) begin n_fail++; $display("FAIL rnd_stall_cnt cyc %0d: got %0d want %0d", cyc, bus.o_stall_cnt, m_stall); end
      n_checks++; if (bus.o_drain_cnt !== m_drains) begin n_fail++; $display("FAIL rnd_drain_cnt cyc %0d: got %0d want %0d", cyc, bus.o_drain_cnt, m_drains); end
`endif
      tick();
    end
  endtask

  initial begin
    drive_idle();
    model_reset();
    test_reset();
    test_raw();
    test_saturation();
    test_same_cycle();
    test_serial();
    test_flush();
    test_reset_mid_drain();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
